// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared fetch types, NOP encoding and reset PC default
package risc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next fetch address select (redirect or sequential)
module next_pc_sel
    import risc_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        taken_i,
    input  logic        jump_i,
    input  logic [31:0] target_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic redirect;

    assign redirect   = taken_i | jump_i;
    // Sequential path wraps naturally at 2^32.
    assign next_pc_o  = redirect ? word_align(target_i) : (pc_i + 32'd4);
    assign misalign_o = redirect && (target_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch controller
// Optional misaligned-redirect flag output under MISALIGN_TRAP_EN.
module fetch_ctrl
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        branch_taken_i,
    input  logic        is_jump_ctl_i,
    input  logic [31:0] target_addr_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic [31:0] pc_o
);

    fetch_state_e state_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic         valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc_q;
    logic [31:0]  next_pc_d;

`ifdef MISALIGN_TRAP_EN
    logic         misalign_d;
    logic         misalign_q;
`else
    logic         misalign_unused;
`endif

    next_pc_sel u_next_pc_sel (
        .pc_i       (pc_q),
        .taken_i    (branch_taken_i),
        .jump_i     (is_jump_ctl_i),
        .target_i   (target_addr_i),
        .next_pc_o  (next_pc_d),
`ifdef MISALIGN_TRAP_EN
        .misalign_o (misalign_d)
`else
        .misalign_o (misalign_unused)
`endif
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_BOOT;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= RESET_PC;
                end
                // rvalid here can only belong to an abandoned request.
                ST_REQ: begin
                    if (imem_gnt_i) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= ST_HOLD;
                        instr_q <= imem_rdata_i;
                        pc_q    <= addr_q;
                        valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        state_q <= ST_REQ;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= next_pc_d;
`ifdef MISALIGN_TRAP_EN
                        misalign_q <= misalign_d;
`endif
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized check of fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        branch_taken_i = 1'b0;
    logic        is_jump_ctl_i = 1'b0;
    logic [31:0] target_addr_i = '0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .branch_taken_i (branch_taken_i),
        .is_jump_ctl_i  (is_jump_ctl_i),
        .target_addr_i  (target_addr_i),
        .stall_i        (stall_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
`ifdef MISALIGN_TRAP_EN
        .misalign_o     (misalign_o),
`endif
        .pc_o           (pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    // Transaction-level expectation of the visible outputs.
    bit          m_boot = 1'b1;
    bit          m_req = 1'b0;
    bit          m_out = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_addr = RST_PC;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc = RST_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_next();
        m_mis = 1'b0;
        if (reset_i) begin
            m_boot = 1'b1; m_req = 1'b0; m_out = 1'b0; m_valid = 1'b0;
            m_addr = RST_PC; m_instr = NOP; m_pc = RST_PC;
        end else if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1; m_addr = RST_PC;
        end else if (m_req) begin
            if (imem_gnt_i) begin
                m_req = 1'b0; m_out = 1'b1;
            end
        end else if (m_out) begin
            if (imem_rvalid_i) begin
                m_out = 1'b0; m_valid = 1'b1;
                m_instr = mem(m_addr); m_pc = m_addr;
            end
        end else if (m_valid && !stall_i) begin
            m_valid = 1'b0; m_req = 1'b1;
            if (branch_taken_i || is_jump_ctl_i) begin
                m_addr = target_addr_i & ~32'h3;
                m_mis  = (target_addr_i % 4) != 0;
            end else begin
                m_addr = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        chk("req", {31'd0, imem_req_o}, {31'd0, m_req});
        chk("addr", imem_addr_o, m_addr);
        chk("valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
        chk("instr", instr_o, m_instr);
        chk("pc", pc_o, m_pc);
`ifdef MISALIGN_TRAP_EN
        chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
`endif
    endtask

    task automatic step(input bit rst, input bit gnt, input bit rv, input bit stl,
                        input bit br, input bit jmp, input logic [31:0] tgt);
        reset_i        = rst;
        imem_gnt_i     = gnt;
        imem_rvalid_i  = rv;
        stall_i        = stl;
        branch_taken_i = br;
        is_jump_ctl_i  = jmp;
        target_addr_i  = tgt;
        imem_rdata_i   = (rv && m_out) ? mem(m_addr) : $urandom;
        model_next();
        @(posedge clk_i);
        #1;
        compare();
    endtask

    task automatic fetch_one();
        step(0, 1, 0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 0, 32'h0);
    endtask

    task automatic consume(input bit br, input bit jmp, input logic [31:0] tgt);
        step(0, 0, 0, 0, br, jmp, tgt);
    endtask

    initial begin
        // Reset values and first fetch latency.
        step(1, 0, 0, 0, 0, 0, 32'h0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        step(0, 0, 1, 0, 1, 1, 32'h44);
        chk("boot_req", {31'd0, imem_req_o}, 32'd1);
        chk("boot_addr", imem_addr_o, 32'h0);
        step(0, 1, 1, 0, 0, 0, 32'h0);
        chk("wait_valid", {31'd0, instr_valid_o}, 32'd0);
        step(0, 0, 1, 0, 0, 0, 32'h0);
        chk("first_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("first_pc", pc_o, 32'h0);
        chk("first_instr", instr_o, 32'hC0FF_EE00);

        // Sequential fetch 4, 8, C.
        consume(0, 0, 32'h0);
        chk("seq_addr4", imem_addr_o, 32'h4);
        fetch_one();
        chk("seq_instr4", instr_o, 32'hB822_08C4);
        consume(0, 0, 32'h0);
        chk("seq_addr8", imem_addr_o, 32'h8);
        fetch_one();
        consume(0, 0, 32'h0);
        chk("seq_addrC", imem_addr_o, 32'hC);
        fetch_one();
        consume(0, 0, 32'h0);
        fetch_one();
        chk("pc10", pc_o, 32'h10);

        // Taken branch vs fall-through from 0x10.
        consume(1, 0, 32'h40);
        chk("br_taken", imem_addr_o, 32'h40);
        fetch_one();
        consume(0, 1, 32'h10);
        fetch_one();
        consume(0, 0, 32'h40);
        chk("br_not_taken", imem_addr_o, 32'h14);
        fetch_one();

        // Stall freezes outputs; redirect applies on release.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 1, 32'h80);
            chk("stall_pc", pc_o, 32'h14);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
        end
        consume(0, 1, 32'h80);
        chk("jump_release", imem_addr_o, 32'h80);
        fetch_one();

        // Address wrap and withheld grant.
        consume(0, 1, 32'hFFFF_FFFC);
        fetch_one();
        consume(0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 32'h0);
            chk("wrap_addr", imem_addr_o, 32'h0);
            chk("wrap_req", {31'd0, imem_req_o}, 32'd1);
        end
        fetch_one();

`ifdef MISALIGN_TRAP_EN
        consume(0, 1, 32'h42);
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        chk("mis_addr", imem_addr_o, 32'h40);
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk("mis_clear", {31'd0, misalign_o}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 32'h0);
`else
        consume(0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0);
`endif
        // Reset while waiting: late rvalid must be dropped.
        step(1, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 0, 32'h0);
        chk("late_rv_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("restart_addr", imem_addr_o, RST_PC);
        chk("restart_req", {31'd0, imem_req_o}, 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            bit rst, gnt, rv, stl, br, jmp;
            logic [31:0] tgt;
            rst = ($urandom_range(0, 299) == 0);
            gnt = m_req && ($urandom_range(0, 1) == 1);
            if (m_out)
                rv = ($urandom_range(0, 1) == 1);
            else if (m_req || m_boot)
                rv = ($urandom_range(0, 3) == 0);
            else
                rv = 1'b0;
            stl = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 3) == 0);
            jmp = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: tgt = 32'($urandom_range(0, 255));
            endcase
            step(rst, gnt, rv, stl, br, jmp, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 branch_taken_i  input  1  branch outcome from branch_control for the instruction currently presented.
REQ-005 is_jump_ctl_i  input  1  unconditional jump (JAL/JALR) for the instruction currently presented.
REQ-006 target_addr_i  input  32  redirect target, used when branch_taken_i or is_jump_ctl_i is high.
REQ-007 stall_i  input  1  downstream cannot accept; the presented instruction is held.
REQ-008 imem_req_o  output  1  instruction memory request.
REQ-009 imem_addr_o  output  32  request address.
REQ-010 imem_gnt_i  input  1  request accepted this cycle.
REQ-011 imem_rvalid_i  input  1  read data valid.
REQ-012 imem_rdata_i  input  32  read data.
REQ-013 instr_valid_o  output  1  instr_o and pc_o hold a valid instruction.
REQ-014 instr_o  output  32  fetched instruction.
REQ-015 pc_o  output  32  address of instr_o.
REQ-016 misalign_o  output  1  redirect target misaligned; present only with MISALIGN_TRAP_EN.

Function
REQ-017 FSM states SHALL be: BOOT, REQ, WAIT, HOLD.
REQ-018 BOOT SHALL last exactly one cycle after reset and then go to REQ with fetch PC = RESET_PC.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch PC; on imem_gnt_i go to WAIT, otherwise stay; address stable until granted.
REQ-020 WAIT: on imem_rvalid_i capture imem_rdata_i into instr_o, set pc_o = fetch PC, go to HOLD; one outstanding request maximum.
REQ-021 HOLD: instr_valid_o=1; when stall_i=0 the instruction is consumed that cycle.
REQ-022 On consume with branch_taken_i|is_jump_ctl_i: next fetch PC = target_addr_i & ~32'h3; else fetch PC = pc_o + 4 (mod 2^32, wrap to 0 from FFFF_FFFC).
REQ-023 On consume, go to REQ in the next cycle; fetch-to-valid latency = 1 (REQ with gnt) + 1 (WAIT with rvalid) cycles minimum.
REQ-024 branch_taken_i and is_jump_ctl_i SHALL be ignored unless instr_valid_o=1 and stall_i=0.
REQ-025 While stall_i=1 in HOLD, instr_o, pc_o, instr_valid_o SHALL remain unchanged.
REQ-026 instr_valid_o SHALL be 0 in BOOT, REQ, WAIT.
REQ-027 Simultaneous imem_gnt_i and imem_rvalid_i in REQ: rvalid refers to no request, SHALL be ignored.

Reset
REQ-028 Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=RESET_PC, misalign_o=0, state=BOOT.
REQ-029 Reset in WAIT SHALL abandon the outstanding request; an imem_rvalid_i arriving in BOOT or REQ is dropped.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN: when defined, misalign_o asserts for one cycle when a redirect is taken with target_addr_i[1:0] != 0, and fetch proceeds to the masked address; when undefined, misalign_o port is absent and low bits are silently masked.

Structure
REQ-031 risc_pkg SHALL hold the fetch FSM state enum, the NOP encoding constant and the default RESET_PC constant.
REQ-032 Next-PC select SHALL be a sub-module next_pc_sel (combinational: pc, taken, jump, target -> next pc, misalign); all state in fetch_ctrl.

Verification
REQ-033 Reset, gnt and rvalid each one cycle later -> imem_addr_o=0 in REQ, instr_valid_o=1 with pc_o=0 on the cycle after rvalid.
REQ-034 Sequential fetch, no redirects, stall_i=0 -> imem_addr_o sequence 0,4,8,C; instr_o matches memory each time.
REQ-035 pc_o=0x10 consumed with branch_taken_i=1, target 0x40 -> next imem_addr_o=0x40; same with branch_taken_i=0 -> 0x14.
REQ-036 stall_i=1 for 3 cycles in HOLD with is_jump_ctl_i=1 target 0x80 -> outputs frozen, no request; release -> imem_addr_o=0x80.
REQ-037 pc_o=FFFF_FFFC consumed, no redirect -> imem_addr_o=0; gnt withheld 4 cycles -> address held, imem_req_o stays 1.
REQ-038 MISALIGN_TRAP_EN defined, jump target 0x42 -> misalign_o=1 one cycle, imem_addr_o=0x40; reset in WAIT -> late rvalid ignored, fetch restarts at RESET_PC.
